multi_bank: RTL and testbench

MULTI_BANK -- requirements
Module: multi_bank

---
 rtl/multi_bank.sv | 188 ++++++++++++++++++
 tb/tb_multi_bank.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_bank.sv
// ---------------------------------------------------------------------------
// MultiBank: banked word memory with a zero-init sweep after reset.
//
// The address space of 2^ADDR_W words is split across NUM_SUB sub-banks.
// The low address bits select the sub-bank and the remaining bits select
// the row inside it. After reset an FSM walks every row once, writing zero
// to that row in all sub-banks in parallel. User traffic is accepted only
// once that sweep has finished.
//
// Parameters
//   DATA_W   word width in bits
//   ADDR_W   address width; depth is 2^ADDR_W words
//   NUM_SUB  sub-bank count (power of two, 1 .. 2^ADDR_W)
//   OUT_REG  1 adds one output register stage to the read path
//
// Ports
//   vsi_clk               sole clock, rising edge
//   vsi_reset             asynchronous active-high reset
//   vsi_inputChipSelect   write request
//   vsi_inputAddr         write address
//   vsi_inputData         write data
//   vsi_bw                per-bit write enable (1 = bit is written)
//   vsi_outputChipSelect  read request
//   vsi_outputAddr        read address
//   vsi_outputData        read data, held between valid pulses
//   vsi_outputValid       one-cycle pulse per completed read
//   vsi_initBusy          high while the zero-init sweep runs
// ---------------------------------------------------------------------------
module multi_bank #(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 7,
    parameter int NUM_SUB = 2,
    parameter int OUT_REG = 0
) (
    input  logic              vsi_clk,
    input  logic              vsi_reset,
    input  logic              vsi_inputChipSelect,
    input  logic [ADDR_W-1:0] vsi_inputAddr,
    input  logic [DATA_W-1:0] vsi_inputData,
    input  logic [DATA_W-1:0] vsi_bw,
    input  logic              vsi_outputChipSelect,
    input  logic [ADDR_W-1:0] vsi_outputAddr,
    output logic [DATA_W-1:0] vsi_outputData,
    output logic              vsi_outputValid,
    output logic              vsi_initBusy
);

    localparam int SUB_W  = $clog2(NUM_SUB);
    localparam int ROWS   = (2 ** ADDR_W) / NUM_SUB;
    localparam int ROW_W  = (ADDR_W - SUB_W) > 0 ? (ADDR_W - SUB_W) : 1;
    localparam int BANK_W = SUB_W > 0 ? SUB_W : 1;

    localparam logic [ADDR_W-1:0] BANK_MASK = ADDR_W'(NUM_SUB - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    logic [ROW_W-1:0]  rowCnt;

    logic [DATA_W-1:0] mem [NUM_SUB][ROWS];

    logic [BANK_W-1:0] wrBank;
    logic [ROW_W-1:0]  wrRow;
    logic [BANK_W-1:0] rdBank;
    logic [ROW_W-1:0]  rdRow;

    logic              wrFire;
    logic              rdFire;
    logic              sweepEn;
    logic [DATA_W-1:0] wrMerged;
    logic [DATA_W-1:0] rdWord;

    // Split each address into sub-bank (low bits) and row (high bits).
    // Masking before the cast keeps the decode valid for NUM_SUB = 1.
    assign wrBank = BANK_W'(vsi_inputAddr & BANK_MASK);
    assign wrRow  = ROW_W'(vsi_inputAddr >> SUB_W);
    assign rdBank = BANK_W'(vsi_outputAddr & BANK_MASK);
    assign rdRow  = ROW_W'(vsi_outputAddr >> SUB_W);

    // Chip selects only count once the sweep is over. The sweep itself is
    // held off while reset is asserted so it starts cleanly from row 0 on
    // the first edge after release.
    assign wrFire  = (state == RUN) && vsi_inputChipSelect;
    assign rdFire  = (state == RUN) && vsi_outputChipSelect;
    assign sweepEn = (state == INIT) && !vsi_reset;

    // Bit-masked merge of the write into the stored word. A read of the
    // same address in the same cycle is handed the merged word, so a read
    // never observes the stale value of a concurrent write.
    always_comb begin
        wrMerged = (mem[wrBank][wrRow] & ~vsi_bw) | (vsi_inputData & vsi_bw);
        rdWord   = mem[rdBank][rdRow];
        if (wrFire && (vsi_inputAddr == vsi_outputAddr)) begin
            rdWord = wrMerged;
        end
    end

    // Storage array. It has no reset on purpose: contents are only ever
    // cleared by the sweep, which zeroes one row across all sub-banks per
    // cycle. Reads use a separate port, so a write and a read hitting the
    // same sub-bank in one cycle both complete.
    always_ff @(posedge vsi_clk) begin
        if (sweepEn) begin
            for (int b = 0; b < NUM_SUB; b++) begin
                mem[b][rowCnt] <= '0;
            end
        end else if (wrFire) begin
            mem[wrBank][wrRow] <= wrMerged;
        end
    end

    // Init/run FSM. The edge that clears the last row also moves to RUN,
    // so the sweep takes exactly ROWS cycles. RUN is left only by reset.
    always_ff @(posedge vsi_clk or posedge vsi_reset) begin
        if (vsi_reset) begin
            state        <= INIT;
            rowCnt       <= '0;
            vsi_initBusy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    if (rowCnt == LAST_ROW) begin
                        state        <= RUN;
                        rowCnt       <= '0;
                        vsi_initBusy <= 1'b0;
                    end else begin
                        rowCnt <= rowCnt + 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state        <= INIT;
                    rowCnt       <= '0;
                    vsi_initBusy <= 1'b1;
                end
            endcase
        end
    end

    generate
        if (OUT_REG != 0) begin : gOutReg
            logic [DATA_W-1:0] stageData;
            logic              stageValid;

            // Two-stage read pipeline: the sampled word sits in a stage
            // register for one cycle before reaching the output. Reset
            // empties both stages, so in-flight reads never pulse valid.
            always_ff @(posedge vsi_clk or posedge vsi_reset) begin
                if (vsi_reset) begin
                    stageValid      <= 1'b0;
                    stageData       <= '0;
                    vsi_outputValid <= 1'b0;
                    vsi_outputData  <= '0;
                end else begin
                    stageValid      <= rdFire;
                    vsi_outputValid <= stageValid;
                    if (rdFire) begin
                        stageData <= rdWord;
                    end
                    if (stageValid) begin
                        vsi_outputData <= stageData;
                    end
                end
            end
        end else begin : gDirect
            // Single-stage read: data lands on the output right after the
            // sampling edge and holds until the next completed read.
            always_ff @(posedge vsi_clk or posedge vsi_reset) begin
                if (vsi_reset) begin
                    vsi_outputValid <= 1'b0;
                    vsi_outputData  <= '0;
                end else begin
                    vsi_outputValid <= rdFire;
                    if (rdFire) begin
                        vsi_outputData <= rdWord;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_multi_bank.sv
// ---------------------------------------------------------------------------
// Testbench for multi_bank. Two instances share one stimulus stream, one
// built without the output register and one with it. Expected read words are
// pushed per instance, tagged with the cycle on which the pulse is due, and
// checked by a per-instance monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_multi_bank;

    localparam int DW = 128;
    localparam int AW = 7;

    typedef struct {
        logic          wrEn;
        logic [AW-1:0] wrAddr;
        logic [DW-1:0] wrData;
        logic [DW-1:0] bw;
        logic          rdEn;
        logic [AW-1:0] rdAddr;
        logic [DW-1:0] expData;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          vsi_clk;
    logic          vsi_reset;
    logic          vsi_inputChipSelect;
    logic [AW-1:0] vsi_inputAddr;
    logic [DW-1:0] vsi_inputData;
    logic [DW-1:0] vsi_bw;
    logic          vsi_outputChipSelect;
    logic [AW-1:0] vsi_outputAddr;

    logic [DW-1:0] data0, data1;
    logic          valid0, valid1;
    logic          busy0, busy1;

    int   vecCount  = 0;
    int   missCount = 0;
    int   cyc       = 0;
    logic benchRun  = 1'b0;

    exp_t          q0[$];
    exp_t          q1[$];
    exp_t          e0, e1;
    logic [DW-1:0] last0 = '0;
    logic [DW-1:0] last1 = '0;

    localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

    vec_t vecs[21];

    multi_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_SUB(2), .OUT_REG(0)) dut0 (
        .vsi_clk(vsi_clk),
        .vsi_reset(vsi_reset),
        .vsi_inputChipSelect(vsi_inputChipSelect),
        .vsi_inputAddr(vsi_inputAddr),
        .vsi_inputData(vsi_inputData),
        .vsi_bw(vsi_bw),
        .vsi_outputChipSelect(vsi_outputChipSelect),
        .vsi_outputAddr(vsi_outputAddr),
        .vsi_outputData(data0),
        .vsi_outputValid(valid0),
        .vsi_initBusy(busy0)
    );

    multi_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_SUB(2), .OUT_REG(1)) dut1 (
        .vsi_clk(vsi_clk),
        .vsi_reset(vsi_reset),
        .vsi_inputChipSelect(vsi_inputChipSelect),
        .vsi_inputAddr(vsi_inputAddr),
        .vsi_inputData(vsi_inputData),
        .vsi_bw(vsi_bw),
        .vsi_outputChipSelect(vsi_outputChipSelect),
        .vsi_outputAddr(vsi_outputAddr),
        .vsi_outputData(data1),
        .vsi_outputValid(valid1),
        .vsi_initBusy(busy1)
    );

    // Free-running clock, 10 time units per cycle.
    initial vsi_clk = 1'b0;
    always #5 vsi_clk = ~vsi_clk;

    // Cycle counter used to tag when each read pulse is due.
    always @(posedge vsi_clk) cyc++;

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic [DW-1:0] bw,
                                input logic re, input logic [AW-1:0] ra,
                                input logic [DW-1:0] ed);
        vec_t v;
        v.wrEn = we; v.wrAddr = wa; v.wrData = wd; v.bw = bw;
        v.rdEn = re; v.rdAddr = ra; v.expData = ed;
        return v;
    endfunction

    task automatic driveIdle();
        vsi_inputChipSelect  = 1'b0;
        vsi_inputAddr        = '0;
        vsi_inputData        = '0;
        vsi_bw               = '0;
        vsi_outputChipSelect = 1'b0;
        vsi_outputAddr       = '0;
    endtask

    // Drive one vector for one clock edge; while running, a read pushes its
    // expected word for both instances with their respective due cycles.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        vsi_inputChipSelect  = v.wrEn;
        vsi_inputAddr        = v.wrAddr;
        vsi_inputData        = v.wrData;
        vsi_bw               = v.bw;
        vsi_outputChipSelect = v.rdEn;
        vsi_outputAddr       = v.rdAddr;
        if (benchRun && v.rdEn) begin
            e.data = v.expData;
            e.due  = cyc + 1;
            q0.push_back(e);
            e.due  = cyc + 2;
            q1.push_back(e);
        end
        @(posedge vsi_clk);
        #1;
        driveIdle();
    endtask

    // Assert reset asynchronously; anything in flight is expected to vanish.
    task automatic pulseReset();
        vsi_reset = 1'b1;
        benchRun  = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge vsi_clk);
        #1;
        vsi_reset = 1'b0;
    endtask

    // Count falling edges with initBusy high, starting right after release.
    task automatic initSweep(input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge vsi_clk);
            if (busy0) cnt++;
            else break;
        end
        checkOutput(name, DW'(cnt), DW'(64));
        checkOutput({name, "Busy0Low"}, DW'(busy0), '0);
        checkOutput({name, "Busy1Low"}, DW'(busy1), '0);
        benchRun = 1'b1;
    endtask

    // Monitor for the unregistered instance.
    always @(negedge vsi_clk) begin
        if (vsi_reset) begin
            checkOutput("rstValid0", DW'(valid0), '0);
            checkOutput("rstData0", data0, '0);
            checkOutput("rstBusy0", DW'(busy0), DW'(1));
            last0 = '0;
        end else if (q0.size() > 0 && q0[0].due == cyc) begin
            e0 = q0.pop_front();
            checkOutput("pulse0", DW'(valid0), DW'(1));
            checkOutput("data0", data0, e0.data);
            last0 = e0.data;
        end else begin
            checkOutput("noPulse0", DW'(valid0), '0);
            checkOutput("hold0", data0, last0);
        end
    end

    // Monitor for the registered-output instance.
    always @(negedge vsi_clk) begin
        if (vsi_reset) begin
            checkOutput("rstValid1", DW'(valid1), '0);
            checkOutput("rstData1", data1, '0);
            checkOutput("rstBusy1", DW'(busy1), DW'(1));
            last1 = '0;
        end else if (q1.size() > 0 && q1[0].due == cyc) begin
            e1 = q1.pop_front();
            checkOutput("pulse1", DW'(valid1), DW'(1));
            checkOutput("data1", data1, e1.data);
            last1 = e1.data;
        end else begin
            checkOutput("noPulse1", DW'(valid1), '0);
            checkOutput("hold1", data1, last1);
        end
    end

    initial begin
        vec_t idle;
        idle = mk(0, 0, '0, '0, 0, 0, '0);

        vecs[0]  = mk(0, 7'h55, '0, '0, 1, 7'h55, '0);
        vecs[1]  = mk(1, 7'd3, ALL1, ALL1, 0, 0, '0);
        vecs[2]  = mk(1, 7'd3, '0, 128'hFF, 0, 0, '0);
        vecs[3]  = mk(0, 0, '0, '0, 1, 7'd3, {{120{1'b1}}, 8'h00});
        vecs[4]  = mk(1, 7'd9, 128'hA5, ALL1, 1, 7'd9, 128'hA5);
        vecs[5]  = mk(1, 7'd0, 128'd10, ALL1, 0, 0, '0);
        vecs[6]  = mk(1, 7'd1, 128'd11, ALL1, 0, 0, '0);
        vecs[7]  = mk(1, 7'd2, 128'd12, ALL1, 0, 0, '0);
        vecs[8]  = mk(1, 7'd3, 128'd13, ALL1, 0, 0, '0);
        vecs[9]  = mk(0, 0, '0, '0, 1, 7'd0, 128'd10);
        vecs[10] = mk(0, 0, '0, '0, 1, 7'd1, 128'd11);
        vecs[11] = mk(0, 0, '0, '0, 1, 7'd2, 128'd12);
        vecs[12] = mk(0, 0, '0, '0, 1, 7'd3, 128'd13);
        vecs[13] = mk(1, 7'd5, 128'h1234, ALL1, 1, 7'd7, '0);
        vecs[14] = mk(0, 0, '0, '0, 1, 7'd5, 128'h1234);
        vecs[15] = mk(1, 7'd6, 128'hFFFF, '0, 1, 7'd6, '0);
        vecs[16] = mk(1, 7'd9, 128'h0F00, 128'h0FF0, 1, 7'd9, 128'h0F05);
        vecs[17] = idle;
        vecs[18] = mk(0, 0, '0, '0, 1, 7'd127, '0);
        vecs[19] = mk(1, 7'd127, ALL1, ALL1, 1, 7'd126, '0);
        vecs[20] = mk(0, 0, '0, '0, 1, 7'd127, ALL1);

        driveIdle();
        vsi_reset = 1'b1;
        repeat (3) @(posedge vsi_clk);
        #1;
        vsi_reset = 1'b0;
        initSweep("initLen");

        $display("[TB] applying %0d table vectors", $size(vecs));
        for (int i = 0; i < $size(vecs); i++) begin
            applyStimulus(vecs[i]);
        end
        repeat (3) applyStimulus(idle);

        // Reset with reads in flight, then with chip selects held through a
        // half-done sweep, then a second reset that restarts the sweep.
        $display("[TB] reset with reads in flight and mid-sweep");
        applyStimulus(mk(0, 0, '0, '0, 1, 7'd0, 128'd10));
        applyStimulus(mk(0, 0, '0, '0, 1, 7'd1, 128'd11));
        vsi_inputChipSelect  = 1'b1;
        vsi_inputAddr        = 7'd7;
        vsi_inputData        = ALL1;
        vsi_bw               = ALL1;
        vsi_outputChipSelect = 1'b1;
        vsi_outputAddr       = 7'd7;
        pulseReset();
        repeat (32) @(negedge vsi_clk);
        checkOutput("midSweepBusy", DW'(busy0), DW'(1));
        pulseReset();
        initSweep("sweepRestart");
        driveIdle();

        applyStimulus(mk(0, 0, '0, '0, 1, 7'd7, '0));
        applyStimulus(mk(0, 0, '0, '0, 1, 7'd3, '0));
        applyStimulus(mk(0, 0, '0, '0, 1, 7'd9, '0));
        applyStimulus(mk(0, 0, '0, '0, 1, 7'd127, '0));
        applyStimulus(mk(0, 0, '0, '0, 1, 7'd0, '0));
        repeat (4) applyStimulus(idle);

        checkOutput("drain0", DW'(q0.size()), '0);
        checkOutput("drain1", DW'(q1.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
